// File: rtl/fire_alarm_pkg.sv
// Shared types and default constants for the fire-alarm supervisory controller.
package fire_alarm_pkg;

  localparam int unsigned NumZones             = 3;
  localparam int unsigned DefVerifyCycles      = 16;
  localparam int unsigned DefClearCycles       = 64;
  localparam int unsigned DefSilenceCycles     = 1024;
  localparam int unsigned DefSirenHalfPeriod   = 8;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StVerify   = 2'd1,
    StAlarm    = 2'd2,
    StSilenced = 2'd3
  } state_e;

  // Counter width able to hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fire_alarm_if.sv
// Detector/panel/annunciator signal bundle; test_req exists only with FIRE_ALARM_TEST_EN.
interface fire_alarm_if;
  import fire_alarm_pkg::*;

  logic [NumZones-1:0] smoke_detector;
  logic                silence;
`ifdef FIRE_ALARM_TEST_EN
  logic                test_req;
`endif
  logic                alarm_enable;
  logic                siren;
  logic                strobe;
  logic [NumZones-1:0] zone_latched;
  logic [1:0]          state;

`ifdef FIRE_ALARM_TEST_EN
  modport master (output smoke_detector, silence, test_req,
                  input  alarm_enable, siren, strobe, zone_latched, state);
  modport slave  (input  smoke_detector, silence, test_req,
                  output alarm_enable, siren, strobe, zone_latched, state);
`else
  modport master (output smoke_detector, silence,
                  input  alarm_enable, siren, strobe, zone_latched, state);
  modport slave  (input  smoke_detector, silence,
                  output alarm_enable, siren, strobe, zone_latched, state);
`endif

endinterface

// File: rtl/fire_alarm_timer.sv
// Saturating up-counter with clear, load-to-LoadVal and terminal-count (count == Limit) flag.
module fire_alarm_timer #(
  parameter int unsigned Width   = 4,
  parameter int unsigned Limit   = 8,
  parameter int unsigned LoadVal = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  logic inc,
  output logic tc
);

  localparam logic [Width-1:0] LimitV = Width'(Limit);
  localparam logic [Width-1:0] LoadV  = Width'(LoadVal);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = LoadV;
    end else if (inc && (count_q != LimitV)) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tc = (count_q == LimitV);

endmodule

// File: rtl/fire_alarm_ctrl.sv
// Fire-alarm supervisory FSM: verify, alarm, silence with re-arm, auto-clear.
// Optional self-test path enabled by defining FIRE_ALARM_TEST_EN.
module fire_alarm_ctrl
  import fire_alarm_pkg::*;
#(
  parameter int unsigned VERIFY_CYCLES     = DefVerifyCycles,
  parameter int unsigned CLEAR_CYCLES      = DefClearCycles,
  parameter int unsigned SILENCE_CYCLES    = DefSilenceCycles,
  parameter int unsigned SIREN_HALF_PERIOD = DefSirenHalfPeriod
) (
  input logic         clk,
  input logic         rst_n,
  fire_alarm_if.slave bus
);

  state_e              state_q, state_d;
  logic                siren_q, siren_d;
  logic [NumZones-1:0] zone_q, zone_d;

  logic ver_clr, ver_load, ver_inc, ver_tc;
  logic qt_clr, qt_inc, qt_tc;
  logic sil_clr, sil_load, sil_inc, sil_tc;
  logic ph_clr, ph_inc, ph_tc;
  logic quiet, new_zone;

  assign quiet    = (bus.smoke_detector == '0);
  assign new_zone = |(bus.smoke_detector & ~zone_q);

  // Clear and siren-phase timers flag one count early so the action lands on the Nth edge.
  fire_alarm_timer #(.Width(cnt_width(VERIFY_CYCLES)), .Limit(VERIFY_CYCLES), .LoadVal(1)) u_ver (
    .clk(clk), .rst_n(rst_n), .clr(ver_clr), .load(ver_load), .inc(ver_inc), .tc(ver_tc)
  );
  fire_alarm_timer #(.Width(cnt_width(CLEAR_CYCLES)), .Limit(CLEAR_CYCLES - 1), .LoadVal(0)) u_qt (
    .clk(clk), .rst_n(rst_n), .clr(qt_clr), .load(1'b0), .inc(qt_inc), .tc(qt_tc)
  );
  fire_alarm_timer #(.Width(cnt_width(SILENCE_CYCLES)), .Limit(SILENCE_CYCLES), .LoadVal(1)) u_sil (
    .clk(clk), .rst_n(rst_n), .clr(sil_clr), .load(sil_load), .inc(sil_inc), .tc(sil_tc)
  );
  fire_alarm_timer #(.Width(cnt_width(SIREN_HALF_PERIOD)), .Limit(SIREN_HALF_PERIOD - 1),
                     .LoadVal(0)) u_ph (
    .clk(clk), .rst_n(rst_n), .clr(ph_clr), .load(1'b0), .inc(ph_inc), .tc(ph_tc)
  );

  always_comb begin
    state_d  = state_q;
    siren_d  = siren_q;
    zone_d   = zone_q;
    ver_clr  = 1'b0;
    ver_load = 1'b0;
    ver_inc  = 1'b0;
    qt_clr   = 1'b0;
    qt_inc   = 1'b0;
    sil_clr  = 1'b0;
    sil_load = 1'b0;
    sil_inc  = 1'b0;
    ph_clr   = 1'b0;
    ph_inc   = 1'b0;

    unique case (state_q)
      StIdle: begin
`ifdef FIRE_ALARM_TEST_EN
        if (bus.test_req) begin
          state_d = StAlarm;
          siren_d = 1'b1;
          ph_clr  = 1'b1;
        end else
`endif
        if (!quiet) begin
          state_d  = StVerify;
          ver_load = 1'b1;
        end
      end

      StVerify: begin
        if (quiet) begin
          state_d = StIdle;
          ver_clr = 1'b1;
        end else if (ver_tc) begin
          state_d = StAlarm;
          zone_d  = bus.smoke_detector;
          siren_d = 1'b1;
          ph_clr  = 1'b1;
          ver_clr = 1'b1;
        end else begin
          ver_inc = 1'b1;
        end
      end

      StAlarm, StSilenced: begin
        zone_d = zone_q | bus.smoke_detector;
        qt_inc = quiet;
        qt_clr = !quiet;
        if (quiet && qt_tc) begin
          state_d = StIdle;
          zone_d  = '0;
          siren_d = 1'b0;
          qt_clr  = 1'b1;
          sil_clr = 1'b1;
          ph_clr  = 1'b1;
          ver_clr = 1'b1;
        end else if (state_q == StAlarm) begin
          if (bus.silence) begin
            state_d  = StSilenced;
            siren_d  = 1'b0;
            sil_load = 1'b1;
            ph_clr   = 1'b1;
          end else if (ph_tc) begin
            siren_d = ~siren_q;
            ph_clr  = 1'b1;
          end else begin
            ph_inc = 1'b1;
          end
        end else if (new_zone || (!bus.silence && sil_tc)) begin
          state_d = StAlarm;
          siren_d = 1'b1;
          ph_clr  = 1'b1;
          sil_clr = 1'b1;
        end else if (bus.silence) begin
          sil_load = 1'b1;
        end else begin
          sil_inc = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      siren_q <= 1'b0;
      zone_q  <= '0;
    end else begin
      state_q <= state_d;
      siren_q <= siren_d;
      zone_q  <= zone_d;
    end
  end

  assign bus.alarm_enable = (state_q == StAlarm) || (state_q == StSilenced);
  assign bus.strobe       = bus.alarm_enable;
  assign bus.siren        = siren_q;
  assign bus.zone_latched = zone_q;
  assign bus.state        = state_q;

endmodule
